// File: rtl/spi_slave.sv
// SPI mode-0 responder (MSB first) that oversamples the SPI pins in the clk domain and
// exchanges words with an RX FIFO write port and a show-ahead TX FIFO read port.
module spi_slave #(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            scsn,
  input  logic            mosi,
  output logic            miso,
  output logic [DATA-1:0] wdata,
  output logic            wr,
  input  logic            full,
  input  logic [DATA-1:0] rdata,
  output logic            rd,
  input  logic            empty,
  output logic            busy,
  output logic            ovr,
  output logic            udr,
  output logic            abrt
);

  localparam int CW = $clog2(DATA) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  logic [2:0]      sclk_sync_r, scsn_sync_r;
  logic [1:0]      mosi_sync_r;
  logic            sclk_rise_s, sclk_fall_s, scsn_fall_s, scsn_rise_s, mosi_s;

  state_t          state_r, state_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [DATA-1:0] tx_r, tx_n, rx_r, rx_n, wdata_r, wdata_n;
  logic [DATA-1:0] load_word_s, rx_next_s;
  logic            skip_r, skip_n, miso_r, miso_n, busy_r;
  logic            wr_r, wr_n, rd_r, rd_n, ovr_r, ovr_n, udr_r, udr_n, abrt_r, abrt_n;

  // Two-stage synchronizers plus a third stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= 3'b000;
      scsn_sync_r <= 3'b111;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      scsn_sync_r <= {scsn_sync_r[1:0], scsn};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
  assign scsn_fall_s = ~scsn_sync_r[1] & scsn_sync_r[2];
  assign scsn_rise_s = scsn_sync_r[1] & ~scsn_sync_r[2];
  assign mosi_s      = mosi_sync_r[1];

  // An empty TX FIFO is answered with an all-ones fill word.
  assign load_word_s = empty ? {DATA{1'b1}} : rdata;
  assign rx_next_s   = {rx_r[DATA-2:0], mosi_s};

  // Next-state and datapath decisions; chip-select edges win over sclk edges.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    tx_n    = tx_r;
    rx_n    = rx_r;
    skip_n  = skip_r;
    miso_n  = miso_r;
    wdata_n = wdata_r;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    ovr_n   = 1'b0;
    udr_n   = 1'b0;
    abrt_n  = 1'b0;
    case (state_r)
      IDLE: begin
        miso_n = 1'b0;
        cnt_n  = {CW{1'b0}};
        if (scsn_fall_s) begin
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (scsn_rise_s) begin
          state_n = IDLE;
          miso_n  = 1'b0;
        end else begin
          tx_n    = {load_word_s[DATA-2:0], 1'b0};
          miso_n  = load_word_s[DATA-1];
          rd_n    = ~empty;
          udr_n   = empty;
          cnt_n   = {CW{1'b0}};
          skip_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (scsn_rise_s) begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
          miso_n  = 1'b0;
          abrt_n  = (cnt_r != {CW{1'b0}});
        end else if (sclk_rise_s) begin
          skip_n = 1'b0;
          rx_n   = rx_next_s;
          if (cnt_r == LAST_BIT) begin
            wdata_n = rx_next_s;
            wr_n    = ~full;
            ovr_n   = full;
            cnt_n   = {CW{1'b0}};
            // Unshifted so the next fall presents the new word's MSB.
            tx_n    = load_word_s;
            rd_n    = ~empty;
            udr_n   = empty;
          end else begin
            cnt_n = cnt_r + CW'(1);
          end
        end else if (sclk_fall_s) begin
          // A fall seen before any rise carries no data: the MSB is already out.
          if (skip_r) begin
            skip_n = 1'b0;
          end else begin
            miso_n = tx_r[DATA-1];
            tx_n   = {tx_r[DATA-2:0], 1'b0};
          end
        end else begin
          state_n = SHIFT;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CW{1'b0}};
        miso_n  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      tx_r    <= {DATA{1'b0}};
      rx_r    <= {DATA{1'b0}};
      wdata_r <= {DATA{1'b0}};
      skip_r  <= 1'b0;
      miso_r  <= 1'b0;
      busy_r  <= 1'b0;
      wr_r    <= 1'b0;
      rd_r    <= 1'b0;
      ovr_r   <= 1'b0;
      udr_r   <= 1'b0;
      abrt_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      tx_r    <= tx_n;
      rx_r    <= rx_n;
      wdata_r <= wdata_n;
      skip_r  <= skip_n;
      miso_r  <= miso_n;
      busy_r  <= ~scsn_sync_r[1];
      wr_r    <= wr_n;
      rd_r    <= rd_n;
      ovr_r   <= ovr_n;
      udr_r   <= udr_n;
      abrt_r  <= abrt_n;
    end
  end

  assign miso  = miso_r;
  assign wdata = wdata_r;
  assign wr    = wr_r;
  assign rd    = rd_r;
  assign busy  = busy_r;
  assign ovr   = ovr_r;
  assign udr   = udr_r;
  assign abrt  = abrt_r;

endmodule
